// File: rtl/ext_code_responder_pkg.sv
// Shared FSM encoding and sizing constants for the external code-memory responder.
// No logic, no latency; only types and constants.
package ext_code_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  localparam int WAIT_W     = 4;
  localparam int DEF_ADDR_W = 12;

endpackage

// File: rtl/ext_code_responder_if.sv
// Board-side bus between the MCU external code fetch port and the responder, plus preload port.
// Master = MCU/preloader side, slave = responder; no flow control beyond ALE/PSEN strobes.
interface ext_code_responder_if #(
  parameter int ADDR_W = ext_code_responder_pkg::DEF_ADDR_W
);
  logic              ale;
  logic              psen_n;
  logic [7:0]        ad_in;
  logic [7:0]        a_hi;
  logic [7:0]        data_out;
  logic              data_oe;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [7:0]        load_data;
  logic              busy;
  logic [15:0]       fetch_cnt;

  modport master (
    output ale, psen_n, ad_in, a_hi, load_en, load_addr, load_data,
    input  data_out, data_oe, busy, fetch_cnt
  );

  modport slave (
    input  ale, psen_n, ad_in, a_hi, load_en, load_addr, load_data,
    output data_out, data_oe, busy, fetch_cnt
  );
endinterface

// File: rtl/ext_code_responder_code_mem.sv
// Byte RAM, one write port and one registered read port; read returns the old byte on a same-address write.
// Read latency 1 clk; no backpressure, no reset of contents.
module code_mem_1r1w #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [7:0]        wr_dat_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [7:0]        rd_dat_o
);

  logic [7:0] mem_q [2**ADDR_W];
  logic [7:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
    rd_q <= mem_q[rd_addr_i];
  end

  assign rd_dat_o = rd_q;

endmodule

// File: rtl/ext_code_responder.sv
// Latch-plus-ROM responder: latches the address on ALE, answers PSEN low with the code byte after WAIT_STATES clks.
// data_oe rises 1+WAIT_STATES edges after PSEN is first sampled low; ALE aborts any fetch immediately.
module ext_code_responder
  import ext_code_responder_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_STATES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  ext_code_responder_if.slave  bus
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);
  localparam logic [WAIT_W-1:0] CNT_ONE   = WAIT_W'(1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_lat_q;
  logic              addr_valid_q;
  logic              data_oe_q, data_oe_d;
  logic [15:0]       fetch_cnt_q;
  logic              drive_entry;
  logic              busy_d;
  logic [7:0]        rd_dat;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A new address phase overrides whatever fetch is in flight.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.ale) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!bus.psen_n && addr_valid_q) begin
            if (WAIT_STATES == 0) begin
              state_d = ST_DRIVE;
            end else begin
              state_d = ST_WAIT;
              cnt_d   = WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_d = cnt_q - CNT_ONE;
          if (bus.psen_n) begin
            state_d = ST_IDLE;
          end else if (cnt_q == CNT_ONE) begin
            state_d = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (bus.psen_n) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Drive only on cycles that were already DRIVE and stay DRIVE, giving the registered data one clk to settle.
  always_comb begin
    data_oe_d   = (state_q == ST_DRIVE) && (state_d == ST_DRIVE);
    drive_entry = (state_q != ST_DRIVE) && (state_d == ST_DRIVE);
    busy_d      = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lat_q   <= '0;
      addr_valid_q <= 1'b0;
      data_oe_q    <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      if (bus.ale) begin
        addr_lat_q   <= ADDR_W'({bus.a_hi, bus.ad_in});
        addr_valid_q <= 1'b1;
      end else if (drive_entry) begin
        addr_valid_q <= 1'b0;
      end
      data_oe_q <= data_oe_d;
      if (drive_entry) begin
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      end
    end
  end

  code_mem_1r1w #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .wr_en_i   (bus.load_en),
    .wr_addr_i (bus.load_addr),
    .wr_dat_i  (bus.load_data),
    .rd_addr_i (addr_lat_q),
    .rd_dat_o  (rd_dat)
  );

  assign bus.data_out  = data_oe_q ? rd_dat : 8'h00;
  assign bus.data_oe   = data_oe_q;
  assign bus.busy      = busy_d;
  assign bus.fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_ext_code_responder.sv
// Three responders (WAIT_STATES 1, 0, 3) share one stimulus stream; a monitor checks every driven byte.
`timescale 1ns/1ps
module tb_ext_code_responder;

  localparam int AW = 12;
  localparam int WS_TAB [3] = '{1, 0, 3};

  logic          clk = 1'b0;
  logic          reset, ale, psen_n, load_en;
  logic [7:0]    ad_in, a_hi, load_data;
  logic [AW-1:0] load_addr;

  logic [7:0]    dout_v [3];
  logic          oe_v   [3];
  logic          busy_v [3];
  logic [15:0]   fcnt_v [3];

  always #5 clk = ~clk;

  ext_code_responder_if #(.ADDR_W(AW)) bus [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign bus[g].ale       = ale;
    assign bus[g].psen_n    = psen_n;
    assign bus[g].ad_in     = ad_in;
    assign bus[g].a_hi      = a_hi;
    assign bus[g].load_en   = load_en;
    assign bus[g].load_addr = load_addr;
    assign bus[g].load_data = load_data;
    assign dout_v[g] = bus[g].data_out;
    assign oe_v[g]   = bus[g].data_oe;
    assign busy_v[g] = bus[g].busy;
    assign fcnt_v[g] = bus[g].fetch_cnt;

    ext_code_responder #(.ADDR_W(AW), .WAIT_STATES(WS_TAB[g])) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus[g])
    );
  end

  // Reference state: memory image, latched address, per-responder fetch count and "address armed" flag.
  logic [7:0]    mem_m  [4096];
  logic [AW-1:0] lat_m;
  logic [15:0]   fcnt_m [3];
  bit            av_m   [3];
  int            busy_cnt [3];
  logic [7:0]    q0 [$];
  logic [7:0]    q1 [$];
  logic [7:0]    q2 [$];
  int            checks = 0;
  int            errors = 0;

  function automatic void push(input int i, input logic [7:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic int qsize(input int i);
    case (i)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [7:0] pop(input int i);
    case (i)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d(ws=%0d) got %0h expected %0h at %0t", name, i, WS_TAB[i], act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (busy_v[i] === 1'b1) busy_cnt[i]++;
        if (oe_v[i] !== 1'b0) begin
          if (qsize(i) == 0) chk("spurious_oe", i, {31'd0, oe_v[i]}, 32'd0);
          else               chk("data_out", i, {24'd0, dout_v[i]}, {24'd0, pop(i)});
        end
      end
    end
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    cyc();
    load_en   = 1'b0;
    mem_m[a]  = d;
  endtask

  // One PSEN pulse: edge 0 is the first edge that samples psen_n low. ale_at / rst_at / ld_at are
  // edge offsets (or -1) where ALE, reset or a preload to the fetched address are injected.
  task automatic fetch(input logic [15:0] addr, input bit do_ale, input int len, input int ale_at,
                       input int rst_at, input int ld_at, input logic [7:0] ld_dat);
    int         s, ws;
    int         b0   [3];
    int         bexp [3];
    logic [7:0] oldv;
    for (int i = 0; i < 3; i++) b0[i] = busy_cnt[i];
    if (do_ale) begin
      ale = 1'b1; ad_in = addr[7:0]; a_hi = addr[15:8];
      cyc();
      ale = 1'b0;
      cyc();
      lat_m = addr[AW-1:0];
      for (int i = 0; i < 3; i++) av_m[i] = 1'b1;
    end
    s = len;
    if (ale_at >= 0 && ale_at <= s) s = ale_at;
    if (rst_at >= 0 && rst_at <= s) s = rst_at;
    oldv = mem_m[lat_m];
    for (int i = 0; i < 3; i++) begin
      ws = WS_TAB[i];
      bexp[i] = 0;
      if (av_m[i]) begin
        bexp[i] = s;
        for (int e = ws + 1; e <= s - 1; e++) push(i, (ld_at >= 0 && e > ld_at) ? ld_dat : oldv);
        if (s >= ws + 1) begin
          fcnt_m[i] = fcnt_m[i] + 16'd1;
          av_m[i]   = 1'b0;
        end
      end
      if (ale_at == s) av_m[i] = 1'b1;
      if (rst_at == s) begin
        av_m[i]   = 1'b0;
        fcnt_m[i] = 16'd0;
      end
    end
    if (ld_at >= 0 && ld_at <= s) mem_m[lat_m] = ld_dat;
    for (int e = 0; e <= s; e++) begin
      psen_n    = (e < len) ? 1'b0 : 1'b1;
      ale       = (e == ale_at);
      reset     = (e == rst_at);
      load_en   = (e == ld_at);
      load_addr = lat_m;
      load_data = ld_dat;
      cyc();
      if (e == rst_at) begin
        for (int i = 0; i < 3; i++) begin
          chk("rst_data_oe", i, {31'd0, oe_v[i]}, 32'd0);
          chk("rst_data_out", i, {24'd0, dout_v[i]}, 32'd0);
          chk("rst_fetch_cnt", i, {16'd0, fcnt_v[i]}, 32'd0);
          chk("rst_busy", i, {31'd0, busy_v[i]}, 32'd0);
        end
      end
    end
    psen_n = 1'b1; ale = 1'b0; reset = 1'b0; load_en = 1'b0;
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("fetch_cnt", i, {16'd0, fcnt_v[i]}, {16'd0, fcnt_m[i]});
      chk("busy_cycles", i, busy_cnt[i] - b0[i], bexp[i]);
    end
  endtask

  initial begin
    logic [15:0] addr;
    int          len, ale_at, ld_at;
    reset = 1'b1; ale = 1'b0; psen_n = 1'b1; load_en = 1'b0;
    ad_in = '0; a_hi = '0; load_addr = '0; load_data = '0;
    lat_m = '0;
    for (int i = 0; i < 3; i++) begin
      fcnt_m[i] = '0; av_m[i] = 1'b0; busy_cnt[i] = 0;
    end
    cyc();
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("reset_data_oe", i, {31'd0, oe_v[i]}, 32'd0);
      chk("reset_data_out", i, {24'd0, dout_v[i]}, 32'd0);
      chk("reset_busy", i, {31'd0, busy_v[i]}, 32'd0);
      chk("reset_fetch_cnt", i, {16'd0, fcnt_v[i]}, 32'd0);
    end
    reset = 1'b0;
    fork monitor(); join_none

    for (int a = 0; a < 4096; a++) load(a[AW-1:0], 8'($urandom));

    load(12'h034, 8'hA5);
    fetch(16'h0034, 1'b1, 4, -1, -1, -1, 8'h00);   // basic fetch
    load(12'hFFF, 8'h3C);
    fetch(16'hFFFF, 1'b1, 3, -1, -1, -1, 8'h00);   // upper address bits dropped
    fetch(16'h0000, 1'b0, 4, -1, -1, -1, 8'h00);   // no ALE since last fetch
    fetch(16'h0034, 1'b1, 8, 4, -1, -1, 8'h00);    // ALE mid-DRIVE
    fetch(16'h0123, 1'b1, 2, -1, -1, -1, 8'h00);   // short strobe aborts WS=3
    fetch(16'h0034, 1'b1, 8, -1, 6, -1, 8'h00);    // reset during DRIVE
    fetch(16'h0034, 1'b1, 5, -1, -1, -1, 8'h00);   // memory survives reset
    load(12'h010, 8'h11);
    fetch(16'h0010, 1'b1, 6, -1, -1, 2, 8'h22);    // read-before-write during DRIVE

    repeat (120) begin
      addr = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load(addr[AW-1:0], 8'($urandom));
      len = int'($urandom_range(1, 7));
      ale_at = -1;
      if ($urandom_range(0, 5) == 0) ale_at = int'($urandom_range(1, len));
      ld_at = -1;
      if ($urandom_range(0, 3) == 0) ld_at = int'($urandom_range(0, len));
      fetch(addr, ($urandom_range(0, 4) != 0), len, ale_at, -1, ld_at, 8'($urandom));
    end

    for (int i = 0; i < 3; i++) chk("queue_drained", i, qsize(i), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ext_code_responder.md
Name: ext_code_responder

Overview:
- External program-memory responder: the other end of the MCU51 external code fetch (ALE/PSEN, P0 low address, P2 high address).
- Models a latch-plus-ROM device on the board side. It captures the multiplexed address during ALE, then answers a PSEN-low strobe by driving the code byte onto the data lines after a programmable number of wait cycles.
- Used in system benches and FPGA builds with EA=0, in place of a real EPROM.

Parameters:
- ADDR_W, 12, implemented code address bits (depth 2**ADDR_W bytes); upper latched address bits are ignored, so addresses wrap.
- WAIT_STATES, 1, clk cycles between PSEN-low detection and data drive; 0..15 legal.

Ports:
- clk  input  1  single system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- ale  input  1  address latch enable from MCU; high means address valid on ad_in/a_hi.
- psen_n  input  1  program strobe, active low.
- ad_in  input  8  P0 lines during address phase (low address byte).
- a_hi  input  8  P2 lines (high address byte).
- data_out  output  8  code byte toward P0; meaningful only when data_oe=1.
- data_oe  output  1  drive enable for data_out; the board tristates P0 from this.
- load_en  input  1  preload write strobe.
- load_addr  input  ADDR_W  preload address.
- load_data  input  8  preload byte.
- busy  output  1  high in WAIT or DRIVE.
- fetch_cnt  output  16  count of completed fetches (DRIVE entries), wraps at 16'hFFFF->0.

Behaviour:
- Reset (synchronous, active high; also valid mid-operation):
  - Clears state to IDLE, data_oe, data_out, addr_lat, addr_valid, wait counter and fetch_cnt to 0.
  - busy=0.
  - Memory contents are not reset.
- Address capture:
  - Every rising edge with ale=1: addr_lat <= {a_hi,ad_in}[ADDR_W-1:0] and addr_valid <= 1.
  - While ale=0, addr_lat holds the value from the last ale-high cycle.
- FSM states: IDLE, WAIT, DRIVE.
  - IDLE: if ale=0, psen_n=0 and addr_valid=1 -> WAIT with cnt=WAIT_STATES. If WAIT_STATES=0, go straight to DRIVE instead.
  - WAIT: cnt decrements each cycle.
    - At cnt=1 -> DRIVE.
    - psen_n=1 before then -> IDLE (aborted fetch, no count).
  - DRIVE: data_oe=1 and data_out=mem[addr_lat], both registered.
    - Stay in DRIVE while psen_n=0.
    - psen_n=1 -> IDLE, with data_oe=0 from the next edge.
    - Entering DRIVE increments fetch_cnt and clears addr_valid, so one strobe yields one fetch.
  - Any state with ale=1 -> IDLE on the next edge, and data_oe drops; a new address phase overrides everything.
- Latency: psen_n first sampled low at edge n -> data_oe=1 and valid data_out after edge n+1+WAIT_STATES (WAIT_STATES=0: after edge n+1).
- data_out is re-read from memory every DRIVE cycle. A load to addr_lat during DRIVE therefore shows the new byte one cycle after the write edge.
- Preload port: load_en=1 writes mem[load_addr] <= load_data at the edge, in any state. Simultaneous load and read of the same address returns the old byte that cycle (read-before-write).
- psen_n=0 with addr_valid=0 (no ALE since the last fetch or since reset): stay in IDLE, data_oe=0.
- busy = (state != IDLE).

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, WAIT=2'd1, DRIVE=2'd2), WAIT_STATES width constant (4 bits), default ADDR_W.
- One sub-module, code_mem_1r1w: synchronous byte RAM, one write port (load) and one registered read port, depth 2**ADDR_W, no reset.
- Top block holds the address latch, edge/strobe logic, FSM, wait counter and fetch counter.

Test Plan:
- Preload mem[12'h034]=8'hA5; ale=1 with ad_in=8'h34, a_hi=8'h00; ale=0; psen_n=0 at edge n (WAIT_STATES=1) -> data_oe=1 and data_out=8'hA5 after edge n+2; fetch_cnt=1; psen_n=1 -> data_oe=0 next edge.
- WAIT_STATES=0; mem[12'hFFF]=8'h3C; address 16'hFFFF latched -> data_out=8'h3C one edge after psen_n low (upper bits dropped, wrap checked).
- Second psen_n pulse without a new ALE -> data_oe stays 0 and fetch_cnt unchanged. ale=1 raised mid-DRIVE -> data_oe=0 on the next edge and state=IDLE.
- WAIT_STATES=3; psen_n low for only 2 cycles -> data_oe never asserts, fetch_cnt unchanged, busy high for exactly 2 cycles.
- reset=1 during DRIVE -> data_oe=0, data_out=0, fetch_cnt=0, busy=0 after that edge. Memory still returns 8'hA5 on the next full fetch of 12'h034.
- During DRIVE at addr 12'h010 (mem=8'h11), load_en writes 8'h22 to 12'h010 -> data_out=8'h11 on the write edge, 8'h22 on the following edge.
